ring_rand_stream: RTL and testbench

- Parametrised successor to the fixed 4-bit/128-deep ring buffer with random access.
- Stores up to DEPTH words appended by a producer; replays them cyclically from the oldest entry on a valid/ready stream.
- Serves random-access reads by logical index on a separate port with fixed latency.
- Sits between frequency-table loading and the tone-selector readout path.

---
 rtl/ring_rand_pkg.sv | 24 ++
 rtl/ring_rand_prefetch.sv | 89 ++++++++
 rtl/ring_rand_stream.sv | 244 ++++++++++++++++++++++++
 tb/tb_ring_rand_stream.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_rand_pkg.sv
// Shared types and sizing helpers for the ring_rand_stream block.
// No ports; imported by ring_rand_prefetch and ring_rand_stream.
package ring_rand_pkg;

  // Prefetch FIFO depth beyond the RAM read latency.
  localparam int unsigned PF_SLACK      = 2;
  localparam int unsigned RD_LAT_DFLT   = 1;
  localparam int unsigned PF_DEPTH_DFLT = RD_LAT_DFLT + PF_SLACK;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic int unsigned pf_depth_of(input int unsigned rd_lat);
    return rd_lat + PF_SLACK;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } stream_state_t;

endpackage

// File: rtl/ring_rand_prefetch.sv
// Shift-register prefetch FIFO holding {data, index, last} for the stream port.
// The head entry always sits in slot 0, so the outputs come straight from flops.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_flush               drop all entries (push in the same cycle is dropped too)
//   i_push, i_data,
//   i_index, i_last       entry returning from the RAM read pipeline
//   i_pop                 consumer accept (ignored when empty)
//   i_inflight            stream reads issued but not yet pushed
//   o_valid, o_data,
//   o_index, o_last       head entry
//   o_credit_c            room for one more issued read
module ring_rand_prefetch
  import ring_rand_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DEPTH  = PF_DEPTH_DFLT,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_index,
  input  logic              i_last,
  input  logic              i_pop,
  input  logic [CNT_W-1:0]  i_inflight,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_index,
  output logic              o_last,
  output logic              o_credit_c
);

  localparam int unsigned ENT_W = DATA_W + ADDR_W + 1;

  logic [ENT_W-1:0] r_ent [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;

  logic             w_pop;
  logic             w_push;
  logic [CNT_W-1:0] w_wpos;
  logic [CNT_W-1:0] w_cnt_next;

  // Occupancy bookkeeping and issue credit.
  always_comb begin
    w_pop      = i_pop & r_valid;
    w_push     = i_push & ((r_cnt < CNT_W'(DEPTH)) | w_pop) & ~i_flush;
    w_wpos     = r_cnt - CNT_W'(w_pop);
    w_cnt_next = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    if (i_flush) begin
      w_cnt_next = '0;
    end
    o_credit_c = (({1'b0, r_cnt} + {1'b0, i_inflight}) < (CNT_W + 1)'(DEPTH));
  end

  // Shift down on pop, then write the new entry just above the survivors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else begin
      r_cnt   <= w_cnt_next;
      r_valid <= (w_cnt_next != '0);
      if (w_pop && !i_flush) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          r_ent[i] <= r_ent[i+1];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (w_wpos == CNT_W'(i))) begin
          r_ent[i] <= {i_data, i_index, i_last};
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_ent[0][ENT_W-1 -: DATA_W];
  assign o_index = r_ent[0][ADDR_W:1];
  assign o_last  = r_ent[0][0];

endmodule

// File: rtl/ring_rand_stream.sv
// Ring buffer of DEPTH words: appended by a producer, replayed cyclically from
// the oldest entry on a valid/ready stream, and readable by logical index on a
// fixed-latency random-access port. One RAM read port is shared; random reads
// take priority over stream prefetch.
// Build option: RING_RAND_OVERWRITE_EN makes a write while full overwrite the
// oldest entry instead of being dropped.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   clear                         empty the buffer (overflow is kept)
//   wr_data, wr_en                append a word
//   m_data, m_valid, m_ready,
//   m_index, m_last               cyclic stream of stored words
//   count, overflow               fill level, sticky full-write flag
//   rand_rd_en, rand_rd_addr,
//   rand_rd_ack                   random read request / acceptance
//   rand_rd_valid, rand_rd_data,
//   rand_rd_err                   random read response, RD_LAT+1 after ack
module ring_rand_stream
  import ring_rand_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              rand_rd_en,
  input  logic [ADDR_W-1:0] rand_rd_addr,
  output logic              rand_rd_ack,
  output logic              rand_rd_valid,
  output logic [DATA_W-1:0] rand_rd_data,
  output logic              rand_rd_err
);

  localparam int unsigned DEPTH    = depth_of(ADDR_W);
  localparam int unsigned PF_DEPTH = pf_depth_of(RD_LAT);
  localparam int unsigned PF_CW    = $clog2(PF_DEPTH + 1);
  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam int unsigned LAST_STG = RD_LAT - 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic [ADDR_W-1:0] r_iss_idx;
  stream_state_t     r_state;

  // Read pipeline: data plus tags, one stage per cycle of RAM latency.
  logic [DATA_W-1:0] r_pl_data [RD_LAT];
  logic [ADDR_W-1:0] r_pl_idx  [RD_LAT];
  logic [RD_LAT-1:0] r_pl_last;
  logic [RD_LAT-1:0] r_pl_err;
  logic [RD_LAT-1:0] r_pl_svld;
  logic [RD_LAT-1:0] r_pl_rvld;

  logic              r_rand_valid;
  logic [DATA_W-1:0] r_rand_data;
  logic              r_rand_err;

  logic              w_rand_ack;
  logic              w_rand_err;
  logic [CNT_W-1:0]  w_cnt_base;
  logic [ADDR_W-1:0] w_head_base;
  logic              w_full;
  logic              w_store;
  logic              w_ovf_set;
  logic              w_flush;
  logic [ADDR_W-1:0] w_head_next;
  logic [ADDR_W-1:0] w_tail_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_issue;
  logic              w_iss_last;
  logic              w_credit;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [PF_CW-1:0]  w_inflight;
  stream_state_t     w_state_next;

  assign w_rand_ack = rand_rd_en & ~rst & ~clear & ~wr_en;
  assign w_rand_err = ({1'b0, rand_rd_addr} >= r_count);
  assign w_iss_last = ({1'b0, r_iss_idx} == (r_count - CNT_W'(1)));
  assign w_rd_addr  = w_rand_ack ? (r_head + rand_rd_addr) : (r_head + r_iss_idx);

  // Write/clear: clear is applied first, then the write lands on the cleared ring.
  always_comb begin
    w_cnt_base  = clear ? '0 : r_count;
    w_head_base = clear ? r_tail : r_head;
    w_full      = (w_cnt_base == CNT_W'(DEPTH));
    w_head_next = w_head_base;
    w_tail_next = r_tail;
    w_cnt_next  = w_cnt_base;
    w_store     = 1'b0;
    w_ovf_set   = 1'b0;
    if (wr_en) begin
      if (!w_full) begin
        w_store     = 1'b1;
        w_tail_next = r_tail + ADDR_W'(1);
        w_cnt_next  = w_cnt_base + CNT_W'(1);
      end else begin
        w_ovf_set = 1'b1;
`ifdef RING_RAND_OVERWRITE_EN
        w_store     = 1'b1;
        w_tail_next = r_tail + ADDR_W'(1);
        w_head_next = w_head_base + ADDR_W'(1);
`endif
      end
    end
    w_flush = clear | w_store;
  end

  // Stream reads currently inside the RAM pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + PF_CW'(r_pl_svld[i]);
    end
  end

  // Stream FSM next state and issue decision.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    if (w_flush) begin
      w_state_next = (w_cnt_next != '0) ? FILL : IDLE;
    end else begin
      case (r_state)
        IDLE:    if (r_count != '0) w_state_next = FILL;
        FILL:    if (m_valid) w_state_next = RUN;
        RUN:     if (r_count == '0) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
    if ((r_state != IDLE) && !w_flush && !w_rand_ack && w_credit) begin
      w_issue = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // RAM and pipeline payload; no reset needed, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (w_store && !rst) begin
      r_mem[r_tail] <= wr_data;
    end
    r_pl_data[0] <= r_mem[w_rd_addr];
    r_pl_idx[0]  <= r_iss_idx;
    r_pl_last[0] <= w_iss_last;
    r_pl_err[0]  <= w_rand_err;
    for (int i = 1; i < RD_LAT; i++) begin
      r_pl_data[i] <= r_pl_data[i-1];
      r_pl_idx[i]  <= r_pl_idx[i-1];
      r_pl_last[i] <= r_pl_last[i-1];
      r_pl_err[i]  <= r_pl_err[i-1];
    end
  end

  // Pointers, flags, pipeline valids and random-read response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_iss_idx    <= '0;
      r_pl_svld    <= '0;
      r_pl_rvld    <= '0;
      r_rand_valid <= 1'b0;
      r_rand_data  <= '0;
      r_rand_err   <= 1'b0;
    end else begin
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_cnt_next;
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
      if (w_flush) begin
        r_iss_idx <= '0;
      end else if (w_issue) begin
        r_iss_idx <= w_iss_last ? '0 : r_iss_idx + ADDR_W'(1);
      end
      r_pl_svld[0] <= w_issue;
      r_pl_rvld[0] <= w_rand_ack;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pl_svld[i] <= r_pl_svld[i-1];
        r_pl_rvld[i] <= r_pl_rvld[i-1];
      end
      // Stream reads issued against the old contents are discarded.
      if (w_flush) begin
        r_pl_svld <= '0;
      end
      r_rand_valid <= r_pl_rvld[LAST_STG];
      r_rand_err   <= r_pl_rvld[LAST_STG] & r_pl_err[LAST_STG];
      r_rand_data  <= (r_pl_rvld[LAST_STG] && !r_pl_err[LAST_STG]) ?
                      r_pl_data[LAST_STG] : '0;
    end
  end

  ring_rand_prefetch #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (PF_DEPTH),
    .CNT_W  (PF_CW)
  ) u_prefetch (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (w_flush),
    .i_push     (r_pl_svld[LAST_STG]),
    .i_data     (r_pl_data[LAST_STG]),
    .i_index    (r_pl_idx[LAST_STG]),
    .i_last     (r_pl_last[LAST_STG]),
    .i_pop      (m_ready),
    .i_inflight (w_inflight),
    .o_valid    (m_valid),
    .o_data     (m_data),
    .o_index    (m_index),
    .o_last     (m_last),
    .o_credit_c (w_credit)
  );

  assign count         = r_count;
  assign overflow      = r_overflow;
  assign rand_rd_ack   = w_rand_ack;
  assign rand_rd_valid = r_rand_valid;
  assign rand_rd_data  = r_rand_data;
  assign rand_rd_err   = r_rand_err;

endmodule

// File: tb/tb_ring_rand_stream.sv
// Randomized bench for ring_rand_stream against a queue-based model of the
// logical buffer contents, stream position and pending random reads.
module tb_ring_rand_stream;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              clear;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W-1:0] m_index;
  logic              m_last;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              rand_rd_en;
  logic [ADDR_W-1:0] rand_rd_addr;
  logic              rand_rd_ack;
  logic              rand_rd_valid;
  logic [DATA_W-1:0] rand_rd_data;
  logic              rand_rd_err;

  ring_rand_stream #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_index       (m_index),
    .m_last        (m_last),
    .count         (count),
    .overflow      (overflow),
    .rand_rd_en    (rand_rd_en),
    .rand_rd_addr  (rand_rd_addr),
    .rand_rd_ack   (rand_rd_ack),
    .rand_rd_valid (rand_rd_valid),
    .rand_rd_data  (rand_rd_data),
    .rand_rd_err   (rand_rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [3:0]  data;
    bit          err;
  } rd_exp_t;

  int                n_total = 0;
  int                n_bad   = 0;
  int                cyc     = 0;
  logic [DATA_W-1:0] mq[$];
  rd_exp_t           sb[$];
  bit                m_ovf       = 1'b0;
  int                e_idx       = 0;
  int                since_flush = 0;
  bit                prev_rst    = 1'b0;
  bit                prev_valid  = 1'b0;
  bit                prev_stall  = 1'b0;
  bit                chk_nogap   = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_index;
  logic              prev_last;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: check outputs against the model, then apply this cycle's inputs.
  task automatic tick();
    bit      flush;
    bit      exp_ack;
    rd_exp_t e;
    int      a;
    #1;
    cyc++;
    since_flush++;

    if (prev_rst) begin
      check_val("rst_m_valid", m_valid, 0);
      check_val("rst_m_data", m_data, 0);
      check_val("rst_m_index", m_index, 0);
      check_val("rst_m_last", m_last, 0);
      check_val("rst_rand_valid", rand_rd_valid, 0);
      check_val("rst_rand_data", rand_rd_data, 0);
      check_val("rst_rand_err", rand_rd_err, 0);
    end

    check_val("count", count, mq.size());
    check_val("overflow", overflow, m_ovf);
    exp_ack = rand_rd_en & ~rst & ~clear & ~wr_en;
    check_val("rand_ack", rand_rd_ack, exp_ack);

    if (sb.size() > 0 && sb[0].due == cyc) begin
      check_val("rand_valid", rand_rd_valid, 1);
      check_val("rand_data", rand_rd_data, sb[0].data);
      check_val("rand_err", rand_rd_err, sb[0].err);
      void'(sb.pop_front());
    end else begin
      check_val("rand_valid_idle", rand_rd_valid, 0);
    end

    if (since_flush <= RD_LAT + 1) begin
      check_val("flush_gap", m_valid, 0);
    end else if (chk_nogap && prev_valid) begin
      check_val("no_gap", m_valid, 1);
    end
    if (prev_stall) begin
      check_val("stall_valid", m_valid, 1);
      check_val("stall_index", m_index, prev_index);
      check_val("stall_data", m_data, prev_data);
      check_val("stall_last", m_last, prev_last);
    end
    if (m_valid) begin
      check_val("valid_nonempty", mq.size() != 0, 1);
      if (e_idx < mq.size()) begin
        check_val("m_index", m_index, e_idx);
        check_val("m_data", m_data, mq[e_idx]);
        check_val("m_last", m_last, e_idx == mq.size() - 1);
      end
    end

    flush = 1'b0;
    if (m_valid && m_ready && mq.size() != 0) begin
      e_idx = (e_idx + 1) % mq.size();
    end
    if (exp_ack) begin
      a     = int'(rand_rd_addr);
      e.due = cyc + RD_LAT + 1;
      e.err = (a >= mq.size());
      e.data = e.err ? 4'h0 : mq[a];
      sb.push_back(e);
    end

    if (rst) begin
      mq.delete();
      sb.delete();
      m_ovf       = 1'b0;
      e_idx       = 0;
      since_flush = 0;
      prev_stall  = 1'b0;
      prev_valid  = 1'b0;
      prev_rst    = 1'b1;
    end else begin
      prev_rst = 1'b0;
      if (clear) begin
        mq.delete();
        flush = 1'b1;
      end
      if (wr_en) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(wr_data);
          flush = 1'b1;
        end else begin
          m_ovf = 1'b1;
`ifdef RING_RAND_OVERWRITE_EN
          void'(mq.pop_front());
          mq.push_back(wr_data);
          flush = 1'b1;
`endif
        end
      end
      if (flush) begin
        e_idx       = 0;
        since_flush = 0;
      end
      prev_stall = m_valid & ~m_ready & ~flush;
      prev_valid = m_valid;
      prev_data  = m_data;
      prev_index = m_index;
      prev_last  = m_last;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_mix(input int n, input int wr_div);
    for (int i = 0; i < n; i++) begin
      wr_en        = ($urandom_range(0, wr_div - 1) == 0);
      wr_data      = DATA_W'($urandom);
      clear        = ($urandom_range(0, 39) == 0);
      rand_rd_en   = ($urandom_range(0, 2) == 0);
      rand_rd_addr = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 15))
                                                 : ADDR_W'($urandom);
      m_ready      = ($urandom_range(0, 1) == 1);
      tick();
    end
    wr_en      = 1'b0;
    clear      = 1'b0;
    rand_rd_en = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    clear        = 1'b0;
    wr_data      = '0;
    wr_en        = 1'b0;
    m_ready      = 1'b0;
    rand_rd_en   = 1'b0;
    rand_rd_addr = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Five words, continuous readout.
    m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr_en   = 1'b1;
      wr_data = DATA_W'(i);
      tick();
    end
    wr_en     = 1'b0;
    chk_nogap = 1'b1;
    repeat (25) tick();
    chk_nogap = 1'b0;

    // Ready toggling with a random read every third cycle.
    for (int i = 0; i < 60; i++) begin
      m_ready      = ((i % 2) == 0);
      rand_rd_en   = ((i % 3) == 0);
      rand_rd_addr = ADDR_W'($urandom_range(0, 7));
      tick();
    end
    rand_rd_en = 1'b0;
    m_ready    = 1'b1;

    // clear and write together, then build count = 3.
    clear   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 4'hA;
    tick();
    clear   = 1'b0;
    wr_data = 4'hB;
    tick();
    wr_data = 4'hC;
    tick();
    wr_en = 1'b0;

    // Back-to-back random reads: one in range, one out of range.
    rand_rd_en   = 1'b1;
    rand_rd_addr = 7'd1;
    tick();
    rand_rd_addr = 7'd7;
    tick();
    rand_rd_en = 1'b0;
    repeat (4) tick();

    rand_mix(400, 10);

    // Fill to DEPTH and write one more.
    clear = 1'b1;
    tick();
    clear   = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_data = DATA_W'($urandom);
      tick();
    end
    wr_en     = 1'b0;
    chk_nogap = 1'b1;
    repeat (DEPTH + 20) tick();
    chk_nogap = 1'b0;

    rand_mix(200, 4);

    // Reset one cycle after an accepted random read.
    m_ready      = 1'b1;
    rand_rd_en   = 1'b1;
    rand_rd_addr = 7'd0;
    tick();
    rand_rd_en = 1'b0;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
